// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port synchronous RAM between two requesters:
//   port A (CPU fetch/LDR/STR) and port B (loader/debug master).
//   Every transaction takes exactly three cycles: IDLE (capture) ->
//   ACCESS (drive RAM, write commits) -> DONE (ack pulse, read data returned).
//
// Ports
//   clk                     rising-edge clock
//   reset                   synchronous, active-low reset
//   a_req/a_we/a_addr/a_wdata  port A request (held stable until a_ack)
//   a_ack                   port A one-cycle completion pulse
//   a_rdata                 port A read data, valid with a_ack on reads
//   b_*                     same as port A, for port B
//   mem_addr/mem_we/mem_wdata  RAM command outputs
//   mem_rdata               RAM read data, one cycle after mem_addr
//   busy                    1 whenever the FSM is not IDLE
//   owner                   0=A, 1=B; port currently/last granted
//
// Configuration macro
//   ARB_RR_EN  defined  : contended grants alternate (round robin)
//              undefined: fixed priority, A always beats B
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                grant_b;        // winner of this IDLE cycle: 1=B, 0=A
  logic                any_req;
  logic                we_q;           // latched write flag of the granted port
  logic                owner_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   a_rdata_q;
  logic [DATA_W-1:0]   b_rdata_q;
  logic                rd_done;

`ifdef ARB_RR_EN
  logic                last_winner_q;  // 1=B; resets to B so A wins the first contest
`endif

  assign any_req = a_req | b_req;

  // NOTE: every variable assigned in always_comb gets a default at the top so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
`ifdef ARB_RR_EN
    grant_b = (a_req && b_req) ? ~last_winner_q : b_req;
`else
    grant_b = b_req & ~a_req;
`endif
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      owner_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
`ifdef ARB_RR_EN
      last_winner_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        owner_q     <= grant_b;
        we_q        <= grant_b ? b_we    : a_we;
        mem_addr_q  <= grant_b ? b_addr  : a_addr;
        mem_wdata_q <= grant_b ? b_wdata : a_wdata;
`ifdef ARB_RR_EN
        last_winner_q <= grant_b;
`endif
      end
      // Capture read data so it persists after the DONE cycle.
      if (rd_done) begin
        if (owner_q) b_rdata_q <= mem_rdata;
        else         a_rdata_q <= mem_rdata;
      end
    end
  end

  // RAM data for the granted read arrives in DONE; forward it combinationally
  // so it is visible in the same cycle as the ack.
  assign rd_done   = (state_q == DONE) && !we_q;
  assign a_ack     = (state_q == DONE) && !owner_q;
  assign b_ack     = (state_q == DONE) &&  owner_q;
  assign a_rdata   = (rd_done && !owner_q) ? mem_rdata : a_rdata_q;
  assign b_rdata   = (rd_done &&  owner_q) ? mem_rdata : b_rdata_q;
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
//   Expectations follow the ARB_RR_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 9;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr, mem_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic          a_ack, b_ack, mem_we, busy, owner;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;
  int b_ack_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  // Synchronous RAM, one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) if (b_ack === 1'b1) b_ack_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    ram[5]     = 16'hABCD;
    ram[0]     = 16'h1234;
    ram[1]     = 16'h5678;
    ram[9'h1FF] = 16'hBEEF;

    // Reset state
    do_reset();
    check("rst_busy",      busy,      0);
    check("rst_owner",     owner,     0);
    check("rst_a_ack",     a_ack,     0);
    check("rst_b_ack",     b_ack,     0);
    check("rst_mem_we",    mem_we,    0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_a_rdata",   a_rdata,   0);
    check("rst_b_rdata",   b_rdata,   0);

    // 1: A write 0x006 <= 0xABCD
    a_req = 1; a_we = 1; a_addr = 9'h006; a_wdata = 16'hABCD;
    check("t1_c1_busy", busy, 0);
    step(); // cycle 2: ACCESS
    check("t1_c2_mem_we",    mem_we,    1);
    check("t1_c2_mem_addr",  mem_addr,  9'h006);
    check("t1_c2_mem_wdata", mem_wdata, 16'hABCD);
    check("t1_c2_busy",      busy,      1);
    check("t1_c2_a_ack",     a_ack,     0);
    step(); // cycle 3: DONE
    check("t1_c3_mem_we",  mem_we,  0);
    check("t1_c3_a_ack",   a_ack,   1);
    check("t1_c3_b_ack",   b_ack,   0);
    check("t1_c3_a_rdata", a_rdata, 0);
    a_req = 0; a_we = 0;
    step(); // IDLE
    check("t1_idle_a_ack",    a_ack,    0);
    check("t1_idle_busy",     busy,     0);
    check("t1_idle_mem_we",   mem_we,   0);
    check("t1_idle_mem_addr", mem_addr, 9'h006);
    check("t1_ram6",          ram[6],   16'hABCD);
    check("t1_b_ack_cnt",     b_ack_cnt, 0);

    // 2: A read 0x005
    a_req = 1; a_we = 0; a_addr = 9'h005;
    step();
    check("t2_c2_mem_we", mem_we, 0);
    step();
    check("t2_c3_a_ack",   a_ack,   1);
    check("t2_c3_a_rdata", a_rdata, 16'hABCD);
    check("t2_c3_b_rdata", b_rdata, 0);
    a_req = 0;
    step();
    check("t2_hold_a_rdata", a_rdata, 16'hABCD);

    // 3: contended reads A@0x000, B@0x001 (fresh reset in both modes)
    do_reset();
    a_req = 1; a_we = 0; a_addr = 9'h000;
    b_req = 1; b_we = 0; b_addr = 9'h001;
    step();
    check("t3_c2_owner",    owner,    0);
    check("t3_c2_mem_addr", mem_addr, 9'h000);
    step();
    check("t3_c3_a_ack",   a_ack,   1);
    check("t3_c3_b_ack",   b_ack,   0);
    check("t3_c3_a_rdata", a_rdata, 16'h1234);
    a_req = 0;
    step();
    check("t3_c4_busy",  busy,  0);
    check("t3_c4_owner", owner, 0);
    step();
    check("t3_c5_owner",    owner,    1);
    check("t3_c5_mem_addr", mem_addr, 9'h001);
    step();
    check("t3_c6_b_ack",   b_ack,   1);
    check("t3_c6_a_ack",   a_ack,   0);
    check("t3_c6_b_rdata", b_rdata, 16'h5678);
    check("t3_c6_a_rdata", a_rdata, 16'h1234);
    b_req = 0;
    step();
    check("t3_c7_busy", busy, 0);

    // 4: continuous contention, acks every third cycle
    do_reset();
    a_req = 1; a_addr = 9'h000;
    b_req = 1; b_addr = 9'h001;
    for (int k = 1; k <= 12; k++) begin
      logic exp_a, exp_b;
      step();
      exp_a = (k % 3 == 2) && (!RR || ((k / 3) % 2 == 0));
      exp_b = (k % 3 == 2) &&  RR && ((k / 3) % 2 == 1);
      check($sformatf("t4_k%0d_a_ack", k), a_ack, exp_a);
      check($sformatf("t4_k%0d_b_ack", k), b_ack, exp_b);
    end
    a_req = 0; b_req = 0;
    step();

    // 5: reset during ACCESS of a B write
    b_ack_cnt = 0;
    b_req = 1; b_we = 1; b_addr = 9'h009; b_wdata = 16'h5A5A;
    step();
    check("t5_access_mem_we", mem_we, 1);
    check("t5_access_owner",  owner,  1);
    reset = 0; b_req = 0; b_we = 0;
    step();
    check("t5_busy",      busy,      0);
    check("t5_mem_we",    mem_we,    0);
    check("t5_owner",     owner,     0);
    check("t5_mem_addr",  mem_addr,  0);
    check("t5_mem_wdata", mem_wdata, 0);
    check("t5_b_ack",     b_ack,     0);
    check("t5_a_rdata",   a_rdata,   0);
    check("t5_b_rdata",   b_rdata,   0);
    check("t5_ram9",      ram[9],    16'h5A5A);
    reset = 1;
    step();
    step();
    check("t5_b_ack_cnt", b_ack_cnt, 0);
    check("t5_idle_busy", busy, 0);

    // 6: A holds read request through ack -> second ack 3 cycles later
    a_req = 1; a_we = 0; a_addr = 9'h005;
    step();
    step();
    check("t6_ack1",       a_ack,   1);
    check("t6_ack1_rdata", a_rdata, 16'hABCD);
    step();
    check("t6_gap1", a_ack, 0);
    step();
    check("t6_gap2", a_ack, 0);
    a_addr = 9'h1FF;
    step();
    check("t6_ack2",       a_ack,   1);
    check("t6_ack2_rdata", a_rdata, 16'hABCD);
    a_req = 0;
    step();
    check("t6_b_rdata", b_rdata, 0);

    // 7: top address passed through, B read
    b_req = 1; b_we = 0; b_addr = 9'h1FF;
    step();
    check("t7_mem_addr", mem_addr, 9'h1FF);
    step();
    check("t7_b_ack",   b_ack,   1);
    check("t7_b_rdata", b_rdata, 16'hBEEF);
    check("t7_a_rdata", a_rdata, 16'hABCD);
    b_req = 0;
    step();
    check("t7_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
